// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR conversion controller.
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COMPARE,
        RELEASE,
        FINISH
    } sar_state_e;

    // SETTLE 1 + COMPARE 3 + RELEASE 3 when the comparator answers within one clk period.
    localparam int CYCLES_PER_BIT = 7;

    // The counter must be able to hold the timeout value itself.
    function automatic int tmo_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta->q a true two-stage shift; blocking would collapse it.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sar_logic.sv
// SAR controller: walks the trial code MSB->LSB, one comparator handshake per bit.
module sar_logic
    import sar_pkg::*;
#(
    parameter int NBITS       = 8,
    parameter int CMP_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             vop,
    input  logic             von,
    input  logic             done,
    output logic             cmp_clk,
    output logic [NBITS-1:0] dac_code,
    output logic [NBITS-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             cmp_err
);

    localparam int TW = tmo_cnt_width(CMP_TIMEOUT);
    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [TW-1:0]    TMO_LAST = TW'(CMP_TIMEOUT - 1);
    localparam logic [IW-1:0]    IDX_MSB  = IW'(NBITS - 1);
    localparam logic [NBITS-1:0] MSB_CODE = {1'b1, {(NBITS-1){1'b0}}};

    sar_state_e      state;
    logic [TW-1:0]   tmo_cnt;
    logic [IW-1:0]   bit_idx;
    logic            done_s;
    logic            decision;
    logic            tmo_hit;

    sync_2ff u_done_sync (
        .clk   (clk),
        .reset (reset),
        .d     (done),
        .q     (done_s)
    );

    // An ambiguous comparator (vop==von) resolves the bit to 0.
    always_comb begin
        decision = (vop != von) ? vop : 1'b0;
        tmo_hit  = (tmo_cnt == TMO_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            bit_idx    <= '0;
            cmp_clk    <= 1'b0;
            dac_code   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            cmp_err    <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        dac_code <= MSB_CODE;
                        bit_idx  <= IDX_MSB;
                        cmp_err  <= 1'b0;
                        tmo_cnt  <= '0;
                        state    <= SETTLE;
                    end
                end

                SETTLE: begin
                    cmp_clk <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= COMPARE;
                end

                COMPARE: begin
                    if (done_s || tmo_hit) begin
                        dac_code[bit_idx] <= done_s ? decision : 1'b0;
                        if (!done_s || (vop == von)) cmp_err <= 1'b1;
                        cmp_clk <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                // A comparator stuck with done high is flagged but does not stall the conversion.
                RELEASE: begin
                    if (!done_s || tmo_hit) begin
                        if (done_s) cmp_err <= 1'b1;
                        tmo_cnt <= '0;
                        if (bit_idx == '0) begin
                            state <= FINISH;
                        end else begin
                            bit_idx                  <= bit_idx - 1'b1;
                            dac_code[bit_idx - 1'b1] <= 1'b1;
                            state                    <= SETTLE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                FINISH: begin
                    dout       <= dac_code;
                    dout_valid <= 1'b1;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_logic.sv
// Self-checking bench for sar_logic with a behavioural comparator and a binary-search reference model.
module tb_sar_logic;
    import sar_pkg::*;

    localparam int NBITS       = 8;
    localparam int CMP_TIMEOUT = 15;
    localparam int LAT_NORMAL  = NBITS * CYCLES_PER_BIT + 1;
    localparam int LAT_TMO     = NBITS * (1 + CMP_TIMEOUT + 1) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             vop, von, done;
    logic             cmp_clk;
    logic [NBITS-1:0] dac_code, dout;
    logic             dout_valid, busy, cmp_err;

    logic [NBITS-1:0] vip;
    int               cmp_mode;   // 0 normal, 1 never done, 2 vop=von=1
    logic [NBITS-1:0] trials[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    sar_logic #(.NBITS(NBITS), .CMP_TIMEOUT(CMP_TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .vop        (vop),
        .von        (von),
        .done       (done),
        .cmp_clk    (cmp_clk),
        .dac_code   (dac_code),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .cmp_err    (cmp_err)
    );

    always #5 clk = ~clk;

    // Comparator: vin side is dac_code, decision and done follow cmp_clk after 1 time unit.
    initial done = 1'b0;
    assign vop = (cmp_mode == 2) ? 1'b1 : (vip >= dac_code);
    assign von = (cmp_mode == 2) ? 1'b1 : !(vip >= dac_code);
    always @(posedge cmp_clk) begin
        #1;
        if (cmp_mode != 1) done = 1'b1;
    end
    always @(negedge cmp_clk) begin
        #1;
        done = 1'b0;
    end
    always @(posedge cmp_clk) trials.push_back(dac_code);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Trial code presented while resolving bit k: upper bits already decided, bit k set, rest clear.
    function automatic logic [NBITS-1:0] ref_trial(input logic [NBITS-1:0] v, input int k);
        int upper;
        upper = (int'(v) >> (k + 1)) << (k + 1);
        return NBITS'(upper | (1 << k));
    endfunction

    task automatic run_conv(input logic [NBITS-1:0] v, input int m,
                            output logic [NBITS-1:0] d, output int lat,
                            output logic e, output logic e_at_accept);
        vip      = v;
        cmp_mode = m;
        trials.delete();
        start = 1'b1;
        step();
        start       = 1'b0;
        e_at_accept = cmp_err;
        lat = 0;
        while (!dout_valid && lat < 400) begin
            step();
            lat++;
        end
        d = dout;
        e = cmp_err;
    endtask

    typedef struct {
        logic [NBITS-1:0] vin;
        int               mode;
        logic [NBITS-1:0] exp_dout;
        int               exp_lat;
        logic             exp_err;
    } vec_t;

    initial begin
        vec_t             vecs[$];
        logic [NBITS-1:0] got_d;
        int               got_lat;
        logic             got_e, got_e0;
        logic [NBITS-1:0] a5_seq[NBITS];
        int               nvalid;
        logic [NBITS-1:0] last_dout;

        a5_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        vecs = '{
            '{8'hA5, 0, 8'hA5, LAT_NORMAL, 1'b0},
            '{8'h00, 0, 8'h00, LAT_NORMAL, 1'b0},
            '{8'hFF, 0, 8'hFF, LAT_NORMAL, 1'b0},
            '{8'h3C, 0, 8'h3C, LAT_NORMAL, 1'b0},
            '{8'h77, 1, 8'h00, LAT_TMO,    1'b1},
            '{8'h5A, 0, 8'h5A, LAT_NORMAL, 1'b0},
            '{8'h77, 2, 8'h00, LAT_NORMAL, 1'b1},
            '{8'h81, 0, 8'h81, LAT_NORMAL, 1'b0}
        };
        for (int i = 0; i < 6; i++) begin
            logic [NBITS-1:0] r;
            r = NBITS'($urandom_range(0, 255));
            vecs.push_back('{r, 0, r, LAT_NORMAL, 1'b0});
        end

        // Reset state
        vip = '0; cmp_mode = 0; start = 1'b0; reset = 1'b1;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_cmp_clk", cmp_clk, 0);
        check("rst_dac_code", dac_code, 0);
        check("rst_dout", dout, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_cmp_err", cmp_err, 0);
        reset = 1'b0;
        repeat (2) step();

        // Table-driven conversions
        foreach (vecs[i]) begin
            run_conv(vecs[i].vin, vecs[i].mode, got_d, got_lat, got_e, got_e0);
            check($sformatf("v%0d_dout", i), got_d, vecs[i].exp_dout);
            check($sformatf("v%0d_latency", i), got_lat, vecs[i].exp_lat);
            check($sformatf("v%0d_cmp_err", i), got_e, vecs[i].exp_err);
            check($sformatf("v%0d_err_clear_on_start", i), got_e0, 0);
            check($sformatf("v%0d_busy_on_valid", i), busy, 1);
            if (vecs[i].mode == 0) begin
                check($sformatf("v%0d_ntrials", i), trials.size(), NBITS);
                for (int k = 0; k < NBITS && k < trials.size(); k++)
                    check($sformatf("v%0d_trial%0d", i, k), trials[k], ref_trial(vecs[i].vin, NBITS - 1 - k));
            end
            if (vecs[i].vin == 8'hA5 && vecs[i].mode == 0) begin
                for (int k = 0; k < NBITS && k < trials.size(); k++)
                    check($sformatf("a5_seq%0d", k), trials[k], a5_seq[k]);
            end
            step();
            check($sformatf("v%0d_busy_drop", i), busy, 0);
            check($sformatf("v%0d_valid_pulse", i), dout_valid, 0);
            check($sformatf("v%0d_dout_held", i), dout, vecs[i].exp_dout);
            step();
        end

        // Back-to-back with start held high: 0x00 then 0xFF
        vip = 8'h00; cmp_mode = 0; start = 1'b1;
        step();
        got_lat = 0;
        while (!dout_valid && got_lat < 400) begin step(); got_lat++; end
        check("b2b_first_latency", got_lat, LAT_NORMAL);
        check("b2b_first_dout", dout, 8'h00);
        vip = 8'hFF;
        step();
        check("b2b_busy_cont", busy, 1);
        check("b2b_valid_pulse", dout_valid, 0);
        got_lat = 1;
        while (!dout_valid && got_lat < 400) begin step(); got_lat++; end
        start = 1'b0;
        check("b2b_second_latency", got_lat, LAT_NORMAL + 1);
        check("b2b_second_dout", dout, 8'hFF);
        repeat (3) step();

        // Reset at cycle 20 of a conversion
        vip = 8'h55; start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        reset = 1'b1;
        step();
        check("mid_rst_cmp_clk", cmp_clk, 0);
        check("mid_rst_dac_code", dac_code, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dout", dout, 0);
        reset = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (dout_valid) nvalid++;
        end
        check("mid_rst_no_valid", nvalid, 0);

        // Second start at cycle 10 is ignored
        vip = 8'h3C; start = 1'b1;
        step();
        start = 1'b0;
        nvalid = 0;
        last_dout = '0;
        for (int c = 1; c <= 120; c++) begin
            if (c == 10) start = 1'b1;
            if (c == 11) start = 1'b0;
            step();
            if (dout_valid) begin
                nvalid++;
                last_dout = dout;
                check("ign_latency", c, LAT_NORMAL);
            end
        end
        check("ign_valid_count", nvalid, 1);
        check("ign_dout", last_dout, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
